// File: rtl/window_3x3.sv
// 3x3 sliding window over a raster pixel stream, built from two line buffers plus a 3x3 shift array.
// Latency: win_out/win_valid and frame_done one cycle after the accepted pixel.
// Backpressure: none; every pixel_valid cycle is accepted, idle cycles leave all state unchanged.
module window_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic        sof,
    output logic [71:0] win_out,
    output logic        win_valid,
    output logic        frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {
        S_FILL   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   w_col;
    logic [RW-1:0]   w_row;
    logic [CW-1:0]   w_col_nxt;
    logic [RW-1:0]   w_row_nxt;
    logic            w_col_last;
    logic            w_row_last;

    logic [7:0]      r_line0 [0:IMG_W-1];
    logic [7:0]      r_line1 [0:IMG_W-1];
    logic [7:0]      w_lb0;
    logic [7:0]      w_lb1;

    // Middle and right columns of the window, indexed by row (0 = top).
    logic [2:0][7:0] r_col_mid;
    logic [2:0][7:0] r_col_right;
    logic [2:0][7:0] w_col_new;
    logic [71:0]     w_win_nxt;

    logic            w_strobe;
    logic            w_done;
    logic [71:0]     r_win_out;
    logic            r_win_valid;
    logic            r_frame_done;

    // A sof pixel is treated as position (0,0) regardless of where the counters were.
    assign w_col      = sof ? '0 : r_col;
    assign w_row      = sof ? '0 : r_row;
    assign w_col_last = (w_col == COL_LAST);
    assign w_row_last = (w_row == ROW_LAST);

    always_comb begin
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = w_row_last ? '0 : w_row + 1'b1;
        end
    end

    assign w_lb0 = r_line0[w_col];
    assign w_lb1 = r_line1[w_col];

    // Line buffers carry no reset; rows 0 and 1 of every frame overwrite them before use.
    always_ff @(posedge clk) begin
        if (pixel_valid && !rst) begin
            r_line1[w_col] <= w_lb0;
            r_line0[w_col] <= pixel_in;
        end
    end

    assign w_col_new[0] = w_lb1;
    assign w_col_new[1] = w_lb0;
    assign w_col_new[2] = pixel_in;

    always_comb begin
        w_win_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[(3*r+0)*8 +: 8] = r_col_mid[r];
            w_win_nxt[(3*r+1)*8 +: 8] = r_col_right[r];
            w_win_nxt[(3*r+2)*8 +: 8] = w_col_new[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_strobe    = 1'b0;
        w_done      = 1'b0;
        if (pixel_valid) begin
            if (sof) begin
                w_state_nxt = S_FILL;
            end else begin
                case (r_state)
                    S_FILL: begin
                        if (w_col_last && (w_row == RW'(1))) begin
                            w_state_nxt = S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        // Columns 0 and 1 would straddle the line wrap, so they never strobe.
                        w_strobe = (w_col >= CW'(2));
                        if (w_col_last && w_row_last) begin
                            w_done      = 1'b1;
                            w_state_nxt = S_FILL;
                        end
                    end
                    default: w_state_nxt = S_FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_col_mid    <= '0;
            r_col_right  <= '0;
            r_win_out    <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_strobe;
            r_frame_done <= w_done;
            if (pixel_valid) begin
                r_col       <= w_col_nxt;
                r_row       <= w_row_nxt;
                r_col_mid   <= r_col_right;
                r_col_right <= w_col_new;
                if (w_strobe) begin
                    r_win_out <= w_win_nxt;
                end
            end
        end
    end

    assign win_out    = r_win_out;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule
